// File: rtl/pe_sched_pkg.sv
// Shared state encoding and parameter defaults for the PE-array tile scheduler.
// No logic; imported by the interface, the index counter and the scheduler top.
package pe_sched_pkg;

  localparam int MAC_NUM_DEF   = 4;
  localparam int DIM_W_DEF     = 16;
  localparam int DRAIN_CYC_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/pe_array_sched_if.sv
// Job control, memory-read and PE/output-write strobes between a host and pe_array_sched.
// Pure wiring; master drives job requests, slave (the scheduler) drives everything else.
interface pe_array_sched_if
  import pe_sched_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) ();

  logic             start;
  logic [DIM_W-1:0] cfg_m;
  logic [DIM_W-1:0] cfg_k;
  logic [DIM_W-1:0] cfg_n;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             rd_en;
  logic [DIM_W-1:0] grp_idx;
  logic [DIM_W-1:0] k_idx;
  logic [DIM_W-1:0] n_idx;
  logic             PE_mac_enable;
  logic             PE_clear_acc;
  logic             out_wr_en;
  logic [DIM_W-1:0] out_grp;
  logic [DIM_W-1:0] out_col;

  modport master (
    output start, cfg_m, cfg_k, cfg_n,
    input  busy, done, cfg_err, rd_en, grp_idx, k_idx, n_idx,
           PE_mac_enable, PE_clear_acc, out_wr_en, out_grp, out_col
  );

  modport slave (
    input  start, cfg_m, cfg_k, cfg_n,
    output busy, done, cfg_err, rd_en, grp_idx, k_idx, n_idx,
           PE_mac_enable, PE_clear_acc, out_wr_en, out_grp, out_col
  );

endinterface

// File: rtl/loop_idx_cnt.sv
// Three-level nested wrap counter (k innermost, grp, n outermost) with last-flags.
// Registered indices change one cycle after inc_i; no backpressure, clr_i has priority.
module loop_idx_cnt
  import pe_sched_pkg::*;
#(
  parameter int W = DIM_W_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] k_max_i,
  input  logic [W-1:0] g_max_i,
  input  logic [W-1:0] n_max_i,
  output logic [W-1:0] k_o,
  output logic [W-1:0] g_o,
  output logic [W-1:0] n_o,
  output logic         k_last_o,
  output logic         all_last_o
);

  logic [W-1:0] k_q, k_d;
  logic [W-1:0] g_q, g_d;
  logic [W-1:0] n_q, n_d;
  logic         g_last;
  logic         n_last;

  assign k_last_o   = (k_q == k_max_i);
  assign g_last     = (g_q == g_max_i);
  assign n_last     = (n_q == n_max_i);
  assign all_last_o = k_last_o && g_last && n_last;

  assign k_o = k_q;
  assign g_o = g_q;
  assign n_o = n_q;

  always_comb begin
    k_d = k_q;
    g_d = g_q;
    n_d = n_q;
    if (clr_i) begin
      k_d = '0;
      g_d = '0;
      n_d = '0;
    end else if (inc_i) begin
      if (!k_last_o) begin
        k_d = k_q + W'(1);
      end else begin
        k_d = '0;
        if (!g_last) begin
          g_d = g_q + W'(1);
        end else begin
          g_d = '0;
          n_d = n_last ? '0 : n_q + W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q <= '0;
      g_q <= '0;
      n_q <= '0;
    end else begin
      k_q <= k_d;
      g_q <= g_d;
      n_q <= n_d;
    end
  end

endmodule

// File: rtl/pe_array_sched.sv
// Tile scheduler for a MAC_NUM-row PE array: per tile K reads, clear, DRAIN_CYC wait, one write.
// Outputs registered (1-cycle after start); tile period K+2+DRAIN_CYC; start ignored while busy.
module pe_array_sched
  import pe_sched_pkg::*;
#(
  parameter int MAC_NUM   = MAC_NUM_DEF,
  parameter int DIM_W     = DIM_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  pe_array_sched_if.slave   bus
);

  localparam int               DCNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [DIM_W-1:0] MAC_W  = DIM_W'(MAC_NUM);

  sched_state_e      state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [DIM_W-1:0]  k_max_q, g_max_q, n_max_q;
  logic              cfg_ok;
  logic              latch_cfg;
  logic              cnt_clr, cnt_inc;
  logic              k_last, all_last;
  logic              done_d, cfg_err_d;
  logic [DIM_W-1:0]  k_idx, grp_idx, n_idx;

  logic              busy_q, done_q, cfg_err_q, rd_en_q;
  logic              mac_q, clear_q, wr_q;
  logic [DIM_W-1:0]  out_grp_q, out_col_q;

  assign cfg_ok = (bus.cfg_m != '0) && (bus.cfg_k != '0) && (bus.cfg_n != '0) &&
                  ((bus.cfg_m % MAC_W) == '0);

  // Indices advance inside FEED and once per tile in WRITE, so they hold through DRAIN.
  loop_idx_cnt #(.W(DIM_W)) u_idx (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .k_max_i    (k_max_q),
    .g_max_i    (g_max_q),
    .n_max_i    (n_max_q),
    .k_o        (k_idx),
    .g_o        (grp_idx),
    .n_o        (n_idx),
    .k_last_o   (k_last),
    .all_last_o (all_last)
  );

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    latch_cfg = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            state_d   = FEED;
            latch_cfg = 1'b1;
            cnt_clr   = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      FEED: begin
        if (k_last) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt_q == DCNT_W'(DRAIN_CYC)) begin
          state_d = WRITE;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      WRITE: begin
        if (all_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = FEED;
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_max_q <= '0;
      g_max_q <= '0;
      n_max_q <= '0;
    end else if (latch_cfg) begin
      k_max_q <= bus.cfg_k - DIM_W'(1);
      g_max_q <= (bus.cfg_m / MAC_W) - DIM_W'(1);
      n_max_q <= bus.cfg_n - DIM_W'(1);
    end
  end

  // Strobes are registered from the upcoming state; MAC trails each FEED cycle by one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      rd_en_q   <= 1'b0;
      mac_q     <= 1'b0;
      clear_q   <= 1'b0;
      wr_q      <= 1'b0;
      out_grp_q <= '0;
      out_col_q <= '0;
    end else begin
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      rd_en_q   <= (state_d == FEED);
      mac_q     <= (state_q == FEED);
      clear_q   <= (state_q == DRAIN) && (dcnt_q == '0);
      wr_q      <= (state_d == WRITE);
      if (state_d == WRITE) begin
        out_grp_q <= grp_idx;
        out_col_q <= n_idx;
      end
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.cfg_err       = cfg_err_q;
  assign bus.rd_en         = rd_en_q;
  assign bus.grp_idx       = grp_idx;
  assign bus.k_idx         = k_idx;
  assign bus.n_idx         = n_idx;
  assign bus.PE_mac_enable = mac_q;
  assign bus.PE_clear_acc  = clear_q;
  assign bus.out_wr_en     = wr_q;
  assign bus.out_grp       = out_grp_q;
  assign bus.out_col       = out_col_q;

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed bench for pe_array_sched: cycle-exact strobe/index checks plus a PE/memory model run.
module tb_pe_array_sched;
  import pe_sched_pkg::*;

  localparam int MAC = 4;
  localparam int DW  = 16;
  localparam int DC  = 2;
  localparam int EM  = 32;
  localparam int EK  = 16;
  localparam int EN  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pe_array_sched_if #(.DIM_W(DW)) bus ();

  pe_array_sched #(.MAC_NUM(MAC), .DIM_W(DW), .DRAIN_CYC(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory + PE array model: 1-cycle read latency, clear closes accumulation, DC-cycle drain.
  byte a_mem [EM][EK];
  byte w_mem [EK][EN];
  int  a_q [MAC];
  int  w_q;
  int  acc [MAC];
  int  st1 [MAC];
  int  st2 [MAC];
  int  out_mem [EM][EN];
  int  refm [EM][EN];
  int  gi, ki, ni;

  always @(posedge clk) begin
    gi = int'(bus.grp_idx);
    ki = int'(bus.k_idx);
    ni = int'(bus.n_idx);
    for (int r = 0; r < MAC; r++) begin
      if (bus.rd_en && (gi * MAC + r) < EM && ki < EK && ni < EN)
        a_q[r] <= int'(a_mem[gi * MAC + r][ki]);
      if (!reset_n) acc[r] <= 0;
      else if (bus.PE_clear_acc) begin
        st1[r] <= acc[r];
        acc[r] <= 0;
      end else if (bus.PE_mac_enable) acc[r] <= acc[r] + a_q[r] * w_q;
      st2[r] <= st1[r];
      if (bus.out_wr_en && (int'(bus.out_grp) * MAC + r) < EM && int'(bus.out_col) < EN)
        out_mem[int'(bus.out_grp) * MAC + r][int'(bus.out_col)] <= st2[r];
    end
    if (bus.rd_en && ki < EK && ni < EN) w_q <= int'(w_mem[ki][ni]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] obs_flags();
    return {bus.busy, bus.done, bus.cfg_err, bus.rd_en,
            bus.PE_mac_enable, bus.PE_clear_acc, bus.out_wr_en};
  endfunction

  // Drives one job and checks every cycle from first FEED through the cycle after done.
  task automatic run_job(input int m, input int k, input int n, input int inject_at,
                         input string name);
    int p, g, t, total, tile, r, ek, eg, en;
    logic [6:0] exp_f;
    logic [47:0] exp_i;
    p = k + 2 + DC;
    g = m / MAC;
    t = g * n;
    total = t * p;
    bus.cfg_m = 16'(m);
    bus.cfg_k = 16'(k);
    bus.cfg_n = 16'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c <= total; c++) begin
      if (c < total) begin
        tile = c / p;
        r    = c % p;
        exp_f = {1'b1, 1'b0, 1'b0, (r < k), (r >= 1 && r <= k), (r == k + 1), (r == k + 1 + DC)};
        ek = (r < k) ? r : k - 1;
        eg = tile % g;
        en = tile / g;
      end else begin
        exp_f = 7'b0100000;
        ek = k - 1;
        eg = g - 1;
        en = n - 1;
      end
      exp_i = {16'(ek), 16'(eg), 16'(en)};
      n_tests++;
      if (obs_flags() !== exp_f) begin
        n_fail++;
        $display("FAIL %s flags c=%0d got %b want %b (busy,done,err,rd,mac,clr,wr)",
                 name, c, obs_flags(), exp_f);
      end
      n_tests++;
      if ({bus.k_idx, bus.grp_idx, bus.n_idx} !== exp_i) begin
        n_fail++;
        $display("FAIL %s idx c=%0d got k=%0d g=%0d n=%0d want k=%0d g=%0d n=%0d",
                 name, c, bus.k_idx, bus.grp_idx, bus.n_idx, ek, eg, en);
      end
      if (exp_f[0]) begin
        n_tests++;
        if ({bus.out_grp, bus.out_col} !== {16'(eg), 16'(en)}) begin
          n_fail++;
          $display("FAIL %s out_addr c=%0d got grp=%0d col=%0d want grp=%0d col=%0d",
                   name, c, bus.out_grp, bus.out_col, eg, en);
        end
      end
      if (c == inject_at) begin
        bus.start = 1'b1;
        bus.cfg_m = 16'd4;
        bus.cfg_k = 16'd5;
        bus.cfg_n = 16'd3;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    n_tests++;
    if (obs_flags() !== 7'b0) begin
      n_fail++;
      $display("FAIL %s after_done got %b want 0000000", name, obs_flags());
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({obs_flags(), bus.k_idx, bus.grp_idx, bus.n_idx, bus.out_grp, bus.out_col} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got flags=%b k=%0d g=%0d n=%0d want all 0",
               obs_flags(), bus.k_idx, bus.grp_idx, bus.n_idx);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_tests++;
    if (obs_flags() !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_idle got %b want 0000000", obs_flags());
    end
  endtask

  task automatic test_cfg_err();
    int bad [4][3] = '{'{6, 3, 2}, '{8, 0, 2}, '{0, 3, 2}, '{8, 3, 0}};
    for (int i = 0; i < 4; i++) begin
      bus.cfg_m = 16'(bad[i][0]);
      bus.cfg_k = 16'(bad[i][1]);
      bus.cfg_n = 16'(bad[i][2]);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n_tests++;
      if (obs_flags() !== 7'b0010000) begin
        n_fail++;
        $display("FAIL cfg_err_pulse case=%0d got %b want 0010000", i, obs_flags());
      end
      tick();
      n_tests++;
      if (obs_flags() !== 7'b0) begin
        n_fail++;
        $display("FAIL cfg_err_clear case=%0d got %b want 0000000", i, obs_flags());
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.cfg_m = 16'd8;
    bus.cfg_k = 16'd3;
    bus.cfg_n = 16'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    n_tests++;
    if (obs_flags() !== 7'b1001100 || bus.grp_idx !== 16'd0 || bus.n_idx !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_job_pre got %b g=%0d n=%0d want 1001100 g=0 n=1",
               obs_flags(), bus.grp_idx, bus.n_idx);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({obs_flags(), bus.k_idx, bus.grp_idx, bus.n_idx, bus.out_grp, bus.out_col} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async got flags=%b k=%0d g=%0d n=%0d want all 0",
               obs_flags(), bus.k_idx, bus.grp_idx, bus.n_idx);
    end
    repeat (3) begin
      tick();
      n_tests++;
      if (obs_flags() !== 7'b0) begin
        n_fail++;
        $display("FAIL mid_reset_hold got %b want 0000000", obs_flags());
      end
    end
    reset_n = 1'b1;
    run_job(8, 3, 2, -1, "post_reset");
  endtask

  task automatic test_e2e();
    for (int i = 0; i < EM; i++)
      for (int j = 0; j < EK; j++) a_mem[i][j] = byte'($urandom_range(0, 255));
    for (int i = 0; i < EK; i++)
      for (int j = 0; j < EN; j++) w_mem[i][j] = byte'($urandom_range(0, 255));
    for (int i = 0; i < EM; i++)
      for (int c = 0; c < EN; c++) begin
        refm[i][c] = 0;
        out_mem[i][c] = 32'h7fff_ffff;
        for (int j = 0; j < EK; j++) refm[i][c] += int'(a_mem[i][j]) * int'(w_mem[j][c]);
      end
    run_job(EM, EK, EN, -1, "e2e");
    for (int i = 0; i < EM; i++)
      for (int c = 0; c < EN; c++) begin
        n_tests++;
        if (out_mem[i][c] !== refm[i][c]) begin
          n_fail++;
          $display("FAIL e2e_out row=%0d col=%0d got %0d want %0d", i, c, out_mem[i][c], refm[i][c]);
        end
      end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cfg_m = '0;
    bus.cfg_k = '0;
    bus.cfg_n = '0;
    test_reset();
    run_job(8, 3, 2, -1, "basic_m8k3n2");
    run_job(4, 1, 1, -1, "single_k1");
    test_cfg_err();
    run_job(8, 3, 2, 5, "start_while_busy");
    run_job(12, 2, 3, -1, "grp3_n3");
    test_reset_mid();
    test_e2e();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_array_sched.md
PE_ARRAY_SCHED -- requirements
Module: pe_array_sched

Interface
REQ-001 SHALL have parameter MAC_NUM, 4, rows processed in parallel by pe_array.
REQ-002 SHALL have parameter DIM_W, 16, width of dimension and index signals.
REQ-003 SHALL have parameter DRAIN_CYC, 2, cycles from PE_clear_acc to valid PE_result_out.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle job request.
REQ-007 SHALL have ports cfg_m / cfg_k / cfg_n  in  DIM_W each  activation rows / reduction length / weight columns.
REQ-008 SHALL have port busy  out  1  job in progress.
REQ-009 SHALL have port done  out  1  one-cycle job-complete pulse.
REQ-010 SHALL have port cfg_err  out  1  one-cycle illegal-config pulse.
REQ-011 SHALL have port rd_en  out  1  activation and weight memory read strobe.
REQ-012 SHALL have ports grp_idx / k_idx / n_idx  out  DIM_W each  row group j, reduction index i, column m.
REQ-013 SHALL have port PE_mac_enable  out  1  to pe_array.
REQ-014 SHALL have port PE_clear_acc  out  1  to pe_array, closes accumulation.
REQ-015 SHALL have port out_wr_en  out  1  capture PE_result_out into output memory.
REQ-016 SHALL have ports out_grp / out_col  out  DIM_W each  write address, row group and column.

Function
REQ-017 SHALL use states IDLE, FEED, DRAIN, WRITE; IDLE->FEED on legal start; FEED->DRAIN after K read cycles; DRAIN->WRITE after clear plus DRAIN_CYC; WRITE->FEED (next tile) or IDLE (last tile, done).
REQ-018 SHALL latch cfg_* on start in IDLE; start while busy SHALL be ignored; cfg changes during job SHALL have no effect.
REQ-019 SHALL reject cfg_m, cfg_k or cfg_n equal to 0, or cfg_m not a multiple of MAC_NUM: pulse cfg_err the next cycle, stay IDLE, busy stays 0.
REQ-020 SHALL iterate tiles with n_idx outermost, grp_idx middle, k_idx innermost (k 0..K-1).
REQ-021 Tile-relative cycle c (c=0 first FEED cycle): rd_en=1 for c=0..K-1 with k_idx=c; PE_mac_enable=1 for c=1..K (rd_en delayed one cycle, matching 1-cycle memory latency).
REQ-022 SHALL assert PE_clear_acc for exactly one cycle at c=K+1.
REQ-023 SHALL assert out_wr_en for exactly one cycle at c=K+1+DRAIN_CYC with out_grp/out_col equal to the tile's grp_idx/n_idx.
REQ-024 Next tile SHALL start at c=K+2+DRAIN_CYC; tile period = K+2+DRAIN_CYC; no overlap between tiles.
REQ-025 busy SHALL rise the cycle after accepted start and fall with done; done SHALL pulse the cycle after the last out_wr_en.
REQ-026 Total job cycles from first FEED to done SHALL equal (M/MAC_NUM)*N*(K+2+DRAIN_CYC).
REQ-027 Index counters SHALL wrap to 0 at bounds (k at K-1, grp at M/MAC_NUM-1, n at N-1) without overflow; K=1 SHALL work.
REQ-028 Outputs SHALL all be registered; index outputs SHALL hold last value when rd_en=0.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE and all outputs and counters to 0, including mid-job; no done pulse SHALL follow.
REQ-030 First start SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-031 Package pe_sched_pkg SHALL hold the state enum and defaults for MAC_NUM, DIM_W, DRAIN_CYC.
REQ-032 One sub-module, loop_idx_cnt (3-level nested wrap counter with last-flags), SHALL generate k/grp/n indices.

Verification
REQ-033 M=8,K=3,N=2,start -> 4 tiles, rd_en k_idx 0,1,2 per tile, clear at c=4, out_wr_en at c=6, done after 28 cycles; (grp,col) order (0,0),(1,0),(0,1),(1,1).
REQ-034 M=4,K=1,N=1 -> single tile: rd_en c=0, mac c=1, clear c=2, wr c=4, done next cycle.
REQ-035 cfg_m=6 (or cfg_k=0) with start -> cfg_err pulse, busy 0, no rd_en.
REQ-036 start with new cfg while busy -> ignored, running job completes with original cycle count.
REQ-037 reset_n low mid-FEED of tile 2 -> outputs 0 immediately, no done; subsequent start runs full job correctly.
REQ-038 End-to-end with pe_array and memory models, M=32,K=16,N=2 random int8 -> output matrix matches reference model, zero mismatches.
